// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, FSM state encoding and CRC constants
// for the VGA sync monitor.
package vga_timing_pkg;

    localparam int DEF_H_TOTAL  = 800;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_TOTAL  = 525;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_CNT_W    = 11;

    localparam logic [1:0] SEARCH  = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/vga_crc16_step.sv
// Combinational CRC-16-CCITT advance over one 12-bit {r,g,b} pixel, MSB first.
// Ports: crc_in (current CRC), data (pixel), crc_out (next CRC).
module vga_crc16_step
    import vga_timing_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [11:0] data,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 11; i >= 0; i--) begin
            if (c[15] ^ data[i])
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            else
                c = {c[14:0], 1'b0};
        end
        crc_out = c;
    end

endmodule

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA checker: measures line/frame timing, checksums the active
// picture and reports lock against the expected timing.
// Ports: clk, reset (async active-low), vga_h_sync/vga_v_sync/vga_r/g/b in;
// meas_valid, meas_h_total, meas_h_sync, meas_v_total, meas_v_sync,
// frame_sum, locked, timing_err out.
// Macro VGA_SYNC_MONITOR_CRC_EN: frame_sum is CRC-16-CCITT instead of a sum.
module vga_sync_monitor
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL     = DEF_H_TOTAL,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_TOTAL     = DEF_V_TOTAL,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int SYNC_NEG    = 1,
    parameter int LOCK_FRAMES = 2,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vga_h_sync,
    input  logic             vga_v_sync,
    input  logic [3:0]       vga_r,
    input  logic [3:0]       vga_g,
    input  logic [3:0]       vga_b,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_h_total,
    output logic [CNT_W-1:0] meas_h_sync,
    output logic [CNT_W-1:0] meas_v_total,
    output logic [CNT_W-1:0] meas_v_sync,
    output logic [15:0]      frame_sum,
    output logic             locked,
    output logic             timing_err
);

    localparam logic [CNT_W-1:0] CMAX  = '1;
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HT_C  = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] HS_C  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VT_C  = CNT_W'(V_TOTAL);
    localparam logic [CNT_W-1:0] VS_C  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] HA0   = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] HA1   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] VA0   = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] VA1   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [7:0]       LF_C  = 8'(LOCK_FRAMES);
    localparam logic             NEG   = (SYNC_NEG != 0);

`ifdef VGA_SYNC_MONITOR_CRC_EN
    localparam logic [15:0] ACC_INIT = CRC_INIT;
`else
    localparam logic [15:0] ACC_INIT = 16'h0000;
`endif

    // Syncs are normalised before the register so a reset value of 0
    // always means "inactive" and cannot fake a leading edge.
    logic             hs_a, vs_a, hs_p, vs_p;
    logic [11:0]      pix;
    logic [CNT_W-1:0] h_cnt, line_cnt, hs_wc, vs_wc, line_len, hs_w;
    logic [15:0]      acc, acc_upd;
    logic             frame_bad;
    logic [1:0]       state;
    logic [7:0]       match_cnt, mc_inc;

    logic             hs_e, vs_e, in_win, bad_now, match, lost;
    logic [CNT_W-1:0] h_inc, l_inc, hw_inc, vw_inc;
    logic [CNT_W-1:0] h_pos, l_pos, line_len_n, hs_w_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_a <= 1'b0;
            vs_a <= 1'b0;
            hs_p <= 1'b0;
            vs_p <= 1'b0;
            pix  <= '0;
        end else begin
            hs_a <= NEG ? ~vga_h_sync : vga_h_sync;
            vs_a <= NEG ? ~vga_v_sync : vga_v_sync;
            hs_p <= hs_a;
            vs_p <= vs_a;
            pix  <= {vga_r, vga_g, vga_b};
        end
    end

    assign hs_e   = hs_a & ~hs_p;
    assign vs_e   = vs_a & ~vs_p;
    assign h_inc  = (h_cnt == CMAX) ? CMAX : h_cnt + ONE;
    assign l_inc  = (line_cnt == CMAX) ? CMAX : line_cnt + ONE;
    assign hw_inc = (hs_wc == CMAX) ? CMAX : hs_wc + ONE;
    assign vw_inc = (vs_wc == CMAX) ? CMAX : vs_wc + ONE;

    // Position of the pixel sampled this cycle; an edge cycle is position 0.
    assign h_pos = hs_e ? '0 : h_inc;
    assign l_pos = vs_e ? '0 : (hs_e ? l_inc : line_cnt);

    // Values including a line that closes in this very cycle.
    assign line_len_n = hs_e ? h_inc : line_len;
    assign hs_w_n     = hs_e ? hs_wc : hs_w;

    assign in_win  = (h_pos >= HA0) && (h_pos < HA1) &&
                     (l_pos >= VA0) && (l_pos < VA1);
    assign bad_now = hs_e && ((line_len_n != HT_C) || (hs_w_n != HS_C));
    assign match   = !(frame_bad || bad_now) &&
                     (l_inc == VT_C) && (vs_wc == VS_C);
    assign lost    = (h_cnt == CMAX) || (line_cnt == CMAX);
    assign mc_inc  = match_cnt + 8'd1;

`ifdef VGA_SYNC_MONITOR_CRC_EN
    vga_crc16_step u_crc (
        .crc_in  (acc),
        .data    (pix),
        .crc_out (acc_upd)
    );
`else
    assign acc_upd = acc + {12'd0, pix[11:8]} + {12'd0, pix[7:4]} +
                     {12'd0, pix[3:0]};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt     <= '0;
            line_cnt  <= '0;
            hs_wc     <= '0;
            vs_wc     <= '0;
            line_len  <= '0;
            hs_w      <= '0;
            frame_bad <= 1'b0;
            acc       <= ACC_INIT;
        end else begin
            h_cnt    <= h_pos;
            line_cnt <= l_pos;
            line_len <= line_len_n;
            hs_w     <= hs_w_n;
            if (hs_e)
                hs_wc <= ONE;
            else if (hs_a)
                hs_wc <= hw_inc;
            // A coincident hsync edge is the first line of the vsync pulse.
            if (vs_e)
                vs_wc <= hs_e ? ONE : '0;
            else if (vs_a && hs_e)
                vs_wc <= vw_inc;
            frame_bad <= vs_e ? 1'b0 : (frame_bad | bad_now);
            if (vs_e)
                acc <= ACC_INIT;
            else if (in_win)
                acc <= acc_upd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= SEARCH;
            match_cnt    <= '0;
            locked       <= 1'b0;
            meas_valid   <= 1'b0;
            timing_err   <= 1'b0;
            meas_h_total <= '0;
            meas_h_sync  <= '0;
            meas_v_total <= '0;
            meas_v_sync  <= '0;
            frame_sum    <= '0;
        end else begin
            meas_valid <= 1'b0;
            timing_err <= 1'b0;
            if (state != SEARCH && lost) begin
                state      <= SEARCH;
                locked     <= 1'b0;
                match_cnt  <= '0;
                timing_err <= 1'b1;
            end else if (vs_e) begin
                if (state == SEARCH) begin
                    state     <= MEASURE;
                    match_cnt <= '0;
                end else begin
                    meas_valid   <= 1'b1;
                    meas_h_total <= line_len_n;
                    meas_h_sync  <= hs_w_n;
                    meas_v_total <= l_inc;
                    meas_v_sync  <= vs_wc;
                    frame_sum    <= acc;
                    if (!match) begin
                        state      <= MEASURE;
                        locked     <= 1'b0;
                        match_cnt  <= '0;
                        timing_err <= 1'b1;
                    end else if (state != LOCKED) begin
                        if (mc_inc >= LF_C) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                        match_cnt <= mc_inc;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboard bench for vga_sync_monitor on a scaled-down video timing, with a
// second instance fed positive-polarity syncs.
module tb_vga_sync_monitor;

    localparam int HT = 40, HS = 6, HBP = 4, HA = 24;
    localparam int VT = 20, VS = 2, VBP = 3, VA = 12;

    typedef struct packed {
        logic [10:0] ht;
        logic [10:0] hs;
        logic [10:0] vt;
        logic [10:0] vs;
        logic [15:0] sum;
        logic        lk;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic h_pin = 1'b1, v_pin = 1'b1;
    logic [3:0] r = '0, g = '0, b = '0;
    logic hp_pin, vp_pin;
    assign hp_pin = ~h_pin;
    assign vp_pin = ~v_pin;

    logic meas_valid, locked, timing_err;
    logic [10:0] meas_h_total, meas_h_sync, meas_v_total, meas_v_sync;
    logic [15:0] frame_sum;
    logic p_valid, p_locked, p_err;
    logic [10:0] p_ht, p_hs, p_vt, p_vs;
    logic [15:0] p_sum;

    vga_sync_monitor #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA),
        .SYNC_NEG(1), .LOCK_FRAMES(2), .CNT_W(11)
    ) dut (
        .clk(clk), .reset(reset),
        .vga_h_sync(h_pin), .vga_v_sync(v_pin),
        .vga_r(r), .vga_g(g), .vga_b(b),
        .meas_valid(meas_valid), .meas_h_total(meas_h_total),
        .meas_h_sync(meas_h_sync), .meas_v_total(meas_v_total),
        .meas_v_sync(meas_v_sync), .frame_sum(frame_sum),
        .locked(locked), .timing_err(timing_err)
    );

    vga_sync_monitor #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA),
        .SYNC_NEG(0), .LOCK_FRAMES(2), .CNT_W(11)
    ) dut_p (
        .clk(clk), .reset(reset),
        .vga_h_sync(hp_pin), .vga_v_sync(vp_pin),
        .vga_r(r), .vga_g(g), .vga_b(b),
        .meas_valid(p_valid), .meas_h_total(p_ht),
        .meas_h_sync(p_hs), .meas_v_total(p_vt),
        .meas_v_sync(p_vs), .frame_sum(p_sum),
        .locked(p_locked), .timing_err(p_err)
    );

    always #5 clk = ~clk;

    int n_run = 0, n_fail = 0;
    int te_cnt = 0, te_p_cnt = 0;
    int hc = 0, vc = 0;
    logic [15:0] model_acc;
    rec_t exp_q[$], obs_q[$], exp_all[$], obs_p[$];

    always @(negedge clk) begin
        rec_t m;
        if (meas_valid) begin
            m = {meas_h_total, meas_h_sync, meas_v_total, meas_v_sync,
                 frame_sum, locked};
            obs_q.push_back(m);
        end
        if (p_valid) begin
            m = {p_ht, p_hs, p_vt, p_vs, p_sum, p_locked};
            obs_p.push_back(m);
        end
        if (timing_err) te_cnt++;
        if (p_err) te_p_cnt++;
    end

`ifdef VGA_SYNC_MONITOR_CRC_EN
    localparam logic [15:0] M_INIT = 16'hFFFF;
    function automatic logic [15:0] model_add(logic [15:0] c, logic [11:0] d);
        for (int i = 11; i >= 0; i--)
            c = (c[15] ^ d[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        return c;
    endfunction
`else
    localparam logic [15:0] M_INIT = 16'h0000;
    function automatic logic [15:0] model_add(logic [15:0] c, logic [11:0] d);
        return c + 16'(d[11:8]) + 16'(d[7:4]) + 16'(d[3:0]);
    endfunction
`endif

    // mode: 0 black, 1 white everywhere, 2 single r=1 at active origin, 3 random
    task automatic emit(input int mode, input int hsl);
        int hw;
        logic [11:0] px;
        bit act;
        hw = (vc == VT - 1) ? hsl : HS;
        act = hc >= HS + HBP && hc < HS + HBP + HA &&
              vc >= VS + VBP && vc < VS + VBP + VA;
        case (mode)
            1: px = 12'hFFF;
            2: px = (hc == HS + HBP && vc == VS + VBP) ? 12'h100 : 12'h000;
            3: px = 12'($urandom);
            default: px = 12'h000;
        endcase
        @(negedge clk);
        h_pin = ~(hc < hw);
        v_pin = ~(vc < VS);
        {r, g, b} = px;
        if (act) model_acc = model_add(model_acc, px);
        hc++;
        if (hc == HT) begin
            hc = 0;
            vc = (vc == VT - 1) ? 0 : vc + 1;
        end
    endtask

    task automatic gen_frame(input int mode, input int hsl, input bit want,
                             input bit lk);
        rec_t e;
        model_acc = M_INIT;
        do emit(mode, hsl); while (!(hc == 0 && vc == 0));
        if (want) begin
            e.ht = 11'(HT); e.hs = 11'(hsl); e.vt = 11'(VT); e.vs = 11'(VS);
            e.sum = model_acc; e.lk = lk;
            exp_q.push_back(e);
            exp_all.push_back(e);
        end
    endtask

    task automatic gen_lead(input int n);
        for (int i = 0; i < n; i++) emit(0, HS);
    endtask

    task automatic gen_until(input int v, input int h);
        int guard = 0;
        while (!(vc == v && hc == h) && guard < HT * VT) begin
            emit(0, HS);
            guard++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_run++;
        if ({meas_valid, locked, timing_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000",
                     {meas_valid, locked, timing_err});
        end
        n_run++;
        if ({meas_h_total, meas_h_sync, meas_v_total, meas_v_sync, frame_sum} !== '0) begin
            n_fail++;
            $display("FAIL reset_meas: got %h %h %h %h %h want 0", meas_h_total,
                     meas_h_sync, meas_v_total, meas_v_sync, frame_sum);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nominal;
        int te0;
        rec_t e, o;
        te0 = te_cnt;
        gen_frame(3, HS, 1, 0);
        gen_frame(3, HS, 1, 1);
        gen_frame(3, HS, 1, 1);
        gen_frame(3, HS, 1, 1);
        gen_lead(5);
        n_run++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL nominal_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL nominal_rec: got %h want %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_run++;
        if (te_cnt - te0 != 0) begin
            n_fail++;
            $display("FAIL nominal_err: got %0d pulses want 0", te_cnt - te0);
        end
    endtask

    task automatic test_checksum;
        rec_t e, o;
        gen_frame(1, HS, 1, 1);
        gen_frame(2, HS, 1, 1);
        gen_lead(5);
        n_run++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL sum_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sum_rec: got %h want %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_hsync_glitch;
        int te0;
        rec_t e, o;
        te0 = te_cnt;
        gen_frame(3, HS - 1, 1, 0);
        gen_frame(3, HS, 1, 0);
        gen_frame(3, HS, 1, 1);
        gen_lead(5);
        n_run++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL glitch_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL glitch_rec: got %h want %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_run++;
        if (te_cnt - te0 != 1) begin
            n_fail++;
            $display("FAIL glitch_err: got %0d pulses want 1", te_cnt - te0);
        end
    endtask

    task automatic test_loss_of_sync;
        int te0;
        rec_t e, o;
        te0 = te_cnt;
        gen_until(8, 10);
        repeat (2100) begin
            @(negedge clk);
            h_pin = 1'b1; v_pin = 1'b1; {r, g, b} = 12'h000;
        end
        n_run++;
        if (te_cnt - te0 != 1 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL loss_detect: got %0d pulses locked=%b want 1 pulse locked=0",
                     te_cnt - te0, locked);
        end
        gen_frame(0, HS, 0, 0);
        gen_frame(3, HS, 1, 0);
        gen_frame(3, HS, 1, 1);
        gen_lead(5);
        n_run++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL loss_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL loss_rec: got %h want %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_run++;
        if (te_cnt - te0 != 1) begin
            n_fail++;
            $display("FAIL loss_err: got %0d pulses want 1", te_cnt - te0);
        end
    endtask

    task automatic test_reset_midframe;
        int te0;
        rec_t e, o;
        te0 = te_cnt;
        gen_until(10, 20);
        n_run++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_lock: got %b want 1", locked);
        end
        #2 reset = 1'b0;
        #1;
        n_run++;
        if ({meas_valid, locked, timing_err, meas_h_total, meas_h_sync,
             meas_v_total, meas_v_sync, frame_sum} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got lk=%b ht=%h hs=%h vt=%h vs=%h sum=%h want 0",
                     locked, meas_h_total, meas_h_sync, meas_v_total, meas_v_sync,
                     frame_sum);
        end
        emit(0, HS); emit(0, HS); emit(0, HS);
        reset = 1'b1;
        gen_frame(0, HS, 0, 0);
        gen_frame(3, HS, 1, 0);
        gen_frame(1, HS, 1, 1);
        gen_lead(5);
        n_run++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rst_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rst_rec: got %h want %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_run++;
        if (te_cnt - te0 != 0) begin
            n_fail++;
            $display("FAIL rst_err: got %0d pulses want 0", te_cnt - te0);
        end
    endtask

    task automatic test_positive_polarity;
        rec_t e, o;
        n_run++;
        if (obs_p.size() != exp_all.size()) begin
            n_fail++;
            $display("FAIL pos_count: got %0d want %0d", obs_p.size(), exp_all.size());
        end
        while (exp_all.size() > 0 && obs_p.size() > 0) begin
            e = exp_all.pop_front(); o = obs_p.pop_front(); n_run++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL pos_rec: got %h want %h", o, e);
            end
        end
        n_run++;
        if (te_p_cnt != 2) begin
            n_fail++;
            $display("FAIL pos_err: got %0d pulses want 2", te_p_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_checksum;
        test_hsync_glitch;
        test_loss_of_sync;
        test_reset_midframe;
        test_positive_polarity;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
